// File: rtl/target_sram_ctrl.sv
// target_sram_ctrl: sequencer and write arbiter for the target-sequence SRAM.
// Streams a range of rows to the alignment engine as SEG_WIDTH-bit segments
// (segment 0 = row LSBs) over valid/ready. Host loader writes are only
// granted while idle, so a row is never rewritten mid-stream.
// Optional build macro TGT_PREFETCH_EN: the next row is read during the
// current row so rows stream back to back with no bubble cycles.
module target_sram_ctrl #(
  parameter int DEPTH      = 18,
  parameter int WIDTHS     = 1920,
  parameter int ADDR_WIDTH = 5,
  parameter int SEG_WIDTH  = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_row,
  input  logic [CNT_WIDTH-1:0]  num_rows,
  output logic                  busy,
  output logic                  done,
  output logic [SEG_WIDTH-1:0]  seg_data,
  output logic                  seg_valid,
  input  logic                  seg_ready,
  output logic                  seg_last,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [WIDTHS-1:0]     ld_data,
  output logic                  ld_gnt,
  output logic                  sram_wEn,
  output logic [ADDR_WIDTH-1:0] sram_wAddr,
  output logic [WIDTHS-1:0]     sram_wData,
  output logic                  sram_rEn,
  output logic [ADDR_WIDTH-1:0] sram_rAddr,
  input  logic [WIDTHS-1:0]     sram_rData
);

  localparam int SEGS  = WIDTHS / SEG_WIDTH;
  localparam int IDX_W = $clog2(SEGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(SEGS - 1);
  localparam logic [CNT_WIDTH-1:0]  ONE_ROW  = CNT_WIDTH'(1);
`ifdef TGT_PREFETCH_EN
  localparam logic [IDX_W-1:0]      IDX_PENULT = IDX_W'(SEGS - 2);
`endif

  typedef enum logic [2:0] {IDLE, READ, WAIT, STREAM, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] curRow;
  logic [CNT_WIDTH-1:0]  rowsLeft;
  logic [IDX_W-1:0]      segIdx;
  logic [IDX_W-1:0]      nxtIdx;
  logic [WIDTHS-1:0]     rowBuf;

  // Pick one segment out of a full row; segment 0 sits in the LSBs.
  function automatic logic [SEG_WIDTH-1:0] segSel(input logic [WIDTHS-1:0] row,
                                                  input logic [IDX_W-1:0] idx);
    return SEG_WIDTH'(row >> (int'(idx) * SEG_WIDTH));
  endfunction

  // Row sequence wraps at the end of the SRAM.
  function automatic logic [ADDR_WIDTH-1:0] nextRow(input logic [ADDR_WIDTH-1:0] r);
    return (r == LAST_ROW) ? '0 : r + ADDR_WIDTH'(1);
  endfunction

  assign nxtIdx = segIdx + IDX_W'(1);

  // Host writes pass straight through, but only while no stream is active.
  assign ld_gnt     = ld_req && (state == IDLE);
  assign sram_wEn   = ld_gnt;
  assign sram_wAddr = ld_addr;
  assign sram_wData = ld_data;

  // Stream sequencer: row fetch, segment handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      curRow     <= '0;
      rowsLeft   <= '0;
      segIdx     <= '0;
      rowBuf     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      seg_valid  <= 1'b0;
      seg_last   <= 1'b0;
      seg_data   <= '0;
      sram_rEn   <= 1'b0;
      sram_rAddr <= '0;
    end else begin
      done     <= 1'b0;
      sram_rEn <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              curRow     <= start_row;
              rowsLeft   <= num_rows;
              busy       <= 1'b1;
              sram_rEn   <= 1'b1;
              sram_rAddr <= start_row;
              state      <= READ;
            end else begin
              // Empty request: report completion without ever going busy.
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          rowBuf    <= sram_rData;
          seg_data  <= sram_rData[SEG_WIDTH-1:0];
          segIdx    <= '0;
          seg_valid <= 1'b1;
          seg_last  <= 1'b0;
          state     <= STREAM;
`ifdef TGT_PREFETCH_EN
          // With two segments per row the prefetch point is segment 0.
          if (IDX_PENULT == '0 && rowsLeft > ONE_ROW) begin
            sram_rEn   <= 1'b1;
            sram_rAddr <= nextRow(curRow);
          end
`endif
        end
        STREAM: begin
          if (seg_ready) begin
            if (segIdx == IDX_LAST) begin
              rowsLeft <= rowsLeft - ONE_ROW;
              curRow   <= nextRow(curRow);
              seg_last <= 1'b0;
              if (rowsLeft == ONE_ROW) begin
                seg_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
`ifdef TGT_PREFETCH_EN
                // Next row was already fetched and is held on sram_rData.
                rowBuf   <= sram_rData;
                seg_data <= sram_rData[SEG_WIDTH-1:0];
                segIdx   <= '0;
                if (IDX_PENULT == '0 && rowsLeft > CNT_WIDTH'(2)) begin
                  sram_rEn   <= 1'b1;
                  sram_rAddr <= nextRow(nextRow(curRow));
                end
`else
                seg_valid  <= 1'b0;
                sram_rEn   <= 1'b1;
                sram_rAddr <= nextRow(curRow);
                state      <= READ;
`endif
              end
            end else begin
              segIdx   <= nxtIdx;
              seg_data <= segSel(rowBuf, nxtIdx);
              seg_last <= (nxtIdx == IDX_LAST) && (rowsLeft == ONE_ROW);
`ifdef TGT_PREFETCH_EN
              if (nxtIdx == IDX_PENULT && rowsLeft > ONE_ROW) begin
                sram_rEn   <= 1'b1;
                sram_rAddr <= nextRow(curRow);
              end
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_sram_ctrl.sv
// Testbench for target_sram_ctrl: SRAM model, segment scoreboard and a
// directed sequence of streaming, stall, wrap, write-arbitration and reset steps.
module tb_target_sram_ctrl;

  localparam int DEPTH = 18;
  localparam int WIDTHS = 1920;
  localparam int AW = 5;
  localparam int SW = 64;
  localparam int CW = 8;
  localparam int SEGS = WIDTHS / SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_row;
  logic [CW-1:0] num_rows;
  logic          busy, done, seg_valid, seg_last;
  logic [SW-1:0] seg_data;
  logic          seg_ready;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [WIDTHS-1:0] ld_data;
  logic          ld_gnt, sram_wEn, sram_rEn;
  logic [AW-1:0] sram_wAddr, sram_rAddr;
  logic [WIDTHS-1:0] sram_wData, sram_rData;

  target_sram_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .start_row(start_row), .num_rows(num_rows),
    .busy(busy), .done(done), .seg_data(seg_data), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .seg_last(seg_last), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_gnt(ld_gnt), .sram_wEn(sram_wEn), .sram_wAddr(sram_wAddr),
    .sram_wData(sram_wData), .sram_rEn(sram_rEn), .sram_rAddr(sram_rAddr),
    .sram_rData(sram_rData)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, one cycle of latency.
  logic [WIDTHS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wEn) mem[sram_wAddr] <= sram_wData;
    if (sram_rEn) sram_rData <= mem[sram_rAddr];
  end

  typedef struct {
    logic [SW-1:0] d;
    logic          l;
  } exp_t;

  exp_t              expQ[$];
  logic [AW-1:0]     rdQ[$];
  logic [WIDTHS-1:0] golden [DEPTH];
  int vectors = 0;
  int miscompares = 0;
  int popped = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTHS-1:0] rowPat(input int r, input int salt);
    logic [WIDTHS-1:0] v;
    v = '0;
    for (int k = 0; k < SEGS; k++)
      v[k*SW +: SW] = (r == 3 && salt == 0) ? 64'(k) : {16'(salt), 16'(r), 32'(k)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for the current cycle and queue the segments it should produce.
  task automatic issueStart(input int sr, input int nr);
    start = 1'b1;
    start_row = AW'(sr);
    num_rows = CW'(nr);
    for (int i = 0; i < nr; i++) begin
      int row;
      row = (sr + i) % DEPTH;
      for (int k = 0; k < SEGS; k++) begin
        exp_t e;
        e.d = golden[row][k*SW +: SW];
        e.l = (i == nr - 1) && (k == SEGS - 1);
        expQ.push_back(e);
      end
    end
  endtask

  // Step cycle by cycle until done is seen; cyc is the cycle index on exit.
  task automatic waitDone(input int c0, input int budget, output int cyc);
    cyc = c0;
    @(negedge clk);
    while (!done && cyc < c0 + budget) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  // Scoreboard and stall-stability monitor.
  logic          prevStall = 1'b0;
  logic [SW-1:0] prevData;
  logic          prevLast;
  always @(negedge clk) begin
    if (!rst) begin
      if (seg_valid && prevStall) begin
        chk("stall_data", seg_data, prevData);
        chk("stall_last", 64'(seg_last), 64'(prevLast));
      end
      if (seg_valid && seg_ready) begin
        chk("sb_nonempty", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          exp_t e;
          e = expQ.pop_front();
          chk("seg_data", seg_data, e.d);
          chk("seg_last", 64'(seg_last), 64'(e.l));
        end
        popped++;
      end
      if (sram_rEn) rdQ.push_back(sram_rAddr);
      prevStall = seg_valid && !seg_ready;
      prevData = seg_data;
      prevLast = seg_last;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    logic flag;
    rst = 1'b1; start = 1'b0; start_row = '0; num_rows = '0; seg_ready = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ctrl", {busy, done, seg_valid, seg_last, sram_rEn, ld_gnt}, 64'd0);
    chk("rst_seg_data", seg_data, 64'd0);
    chk("rst_raddr", 64'(sram_rAddr), 64'd0);
    tick();
    rst = 1'b0;

    // Load every row through the host write port.
    for (int r = 0; r < DEPTH; r++) begin
      ld_req = 1'b1; ld_addr = AW'(r); ld_data = rowPat(r, 0);
      golden[r] = rowPat(r, 0);
      @(negedge clk);
      chk("load_gnt", {ld_gnt, sram_wEn}, 64'd3);
      chk("load_waddr", 64'(sram_wAddr), 64'(r));
      tick();
    end
    ld_req = 1'b0;
    tick();

    // Single row, checking first-segment latency and done timing.
    seg_ready = 1'b1;
    rdQ.delete();
    issueStart(3, 1);
    @(negedge clk);
    chk("t1_c0_busy", 64'(busy), 64'd0);
    tick(); start = 1'b0;
    @(negedge clk);
    chk("t1_read", {busy, sram_rEn, seg_valid}, 64'b110);
    chk("t1_raddr", 64'(sram_rAddr), 64'd3);
    tick();
    @(negedge clk);
    chk("t1_wait", {sram_rEn, seg_valid}, 64'b00);
    tick();
    @(negedge clk);
    chk("t1_first_valid", 64'(seg_valid), 64'd1);
    chk("t1_first_data", seg_data, 64'd0);
    tick();
    waitDone(4, 100, cyc);
    chk("t1_done_cycle", 64'(cyc), 64'd33);
    chk("t1_busy_fall", 64'(busy), 64'd0);
    chk("t1_sb_empty", 64'(expQ.size()), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);
    tick();

    // Two rows wrapping from the last row back to row 0.
    rdQ.delete();
    issueStart(17, 2);
    tick(); start = 1'b0;
    waitDone(1, 200, cyc);
`ifdef TGT_PREFETCH_EN
    chk("t2_done_cycle", 64'(cyc), 64'd63);
`else
    chk("t2_done_cycle", 64'(cyc), 64'd65);
`endif
    chk("t2_reads", 64'(rdQ.size()), 64'd2);
    if (rdQ.size() == 2) begin
      chk("t2_raddr0", 64'(rdQ[0]), 64'd17);
      chk("t2_raddr1", 64'(rdQ[1]), 64'd0);
    end
    chk("t2_sb_empty", 64'(expQ.size()), 64'd0);
    tick(); tick();

    // Backpressure: a 5-cycle stall, then ready toggling every cycle.
    base = popped;
    issueStart(5, 2);
    tick(); start = 1'b0;
    cyc = 0;
    while (popped < base + 10 && cyc < 100) begin tick(); cyc++; end
    seg_ready = 1'b0;
    // A start while busy must be ignored.
    start = 1'b1; start_row = AW'(9); num_rows = CW'(3);
    tick(); start = 1'b0;
    repeat (4) tick();
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 300) begin
      tick();
      seg_ready = ~seg_ready;
      @(negedge clk);
      cyc++;
    end
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_count", 64'(popped - base), 64'(2 * SEGS));
    chk("t3_sb_empty", 64'(expQ.size()), 64'd0);
    seg_ready = 1'b1;
    tick(); tick();

    // Zero-row request.
    rdQ.delete();
    issueStart(4, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_done", 64'(done), 64'(c == 1));
      chk("t4_quiet", {busy, seg_valid, sram_rEn}, 64'd0);
      tick();
      start = 1'b0;
    end
    chk("t4_no_reads", 64'(rdQ.size()), 64'd0);

    // Host write held off for the whole stream, granted once back in IDLE.
    issueStart(1, 1);
    tick(); start = 1'b0;
    ld_req = 1'b1; ld_addr = AW'(2); ld_data = rowPat(2, 1);
    flag = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      flag = flag | ld_gnt | sram_wEn;
      if (done) break;
      tick();
      cyc++;
    end while (cyc < 100);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_stalled", 64'(flag), 64'd0);
    tick();
    @(negedge clk);
    chk("t5_gnt", {ld_gnt, sram_wEn}, 64'd3);
    chk("t5_waddr", 64'(sram_wAddr), 64'd2);
    golden[2] = rowPat(2, 1);
    tick();
    ld_req = 1'b0;
    @(negedge clk);
    chk("t5_gnt_drop", 64'(ld_gnt), 64'd0);
    tick();

    // Write and start to the same row in the same cycle: stream sees new data.
    ld_req = 1'b1; ld_addr = AW'(5); ld_data = rowPat(5, 2);
    golden[5] = rowPat(5, 2);
    issueStart(5, 1);
    @(negedge clk);
    chk("t5b_gnt", 64'(ld_gnt), 64'd1);
    tick(); start = 1'b0; ld_req = 1'b0;
    waitDone(1, 100, cyc);
    chk("t5b_sb_empty", 64'(expQ.size()), 64'd0);
    tick();

    // Reset in the middle of a stream at segment 12.
    base = popped;
    issueStart(2, 2);
    tick(); start = 1'b0;
    cyc = 0;
    while (popped < base + 12 && cyc < 100) begin tick(); cyc++; end
    rst = 1'b1; seg_ready = 1'b0;
    tick();
    rst = 1'b0; seg_ready = 1'b1;
    expQ.delete();
    @(negedge clk);
    chk("t6_after_rst", {seg_valid, busy}, 64'd0);
    flag = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      @(negedge clk);
      flag = flag | done | seg_valid;
    end
    chk("t6_quiet", 64'(flag), 64'd0);
    tick();
    base = popped;
    issueStart(2, 1);
    tick(); start = 1'b0;
    waitDone(1, 100, cyc);
    chk("t6_restart_cycle", 64'(cyc), 64'd33);
    chk("t6_restart_count", 64'(popped - base), 64'(SEGS));
    chk("t6_sb_empty", 64'(expQ.size()), 64'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
